adc_sample_conditioner: RTL and testbench

ADC_SAMPLE_CONDITIONER -- requirements
Module: adc_sample_conditioner

---
 rtl/adc_sample_conditioner_if.sv | 21 ++
 rtl/adc_sample_conditioner.sv | 139 +++++++++++++
 tb/tb_adc_sample_conditioner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_conditioner_if.sv
// ADC response stream plus conditioned-sample output handshake for adc_sample_conditioner.
// The master side drives ADC beats and out_ready; the slave side is the conditioner.
interface adc_sample_conditioner_if;
  logic        adc_response_valid;
  logic [4:0]  adc_response_channel;
  logic [11:0] adc_response_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  overrun_count;

  modport master (
    output adc_response_valid, adc_response_channel, adc_response_data, out_ready,
    input  out_valid, out_data, overrun_count
  );

  modport slave (
    input  adc_response_valid, adc_response_channel, adc_response_data, out_ready,
    output out_valid, out_data, overrun_count
  );
endinterface

// File: rtl/adc_sample_conditioner.sv
// Converts offset-binary ADC beats of one channel into signed 16-bit audio held in a 1-deep overwrite buffer.
// Optional DC removal is compiled in with the macro ADC_DC_REMOVE_EN (adds one pipeline stage).
module adc_sample_conditioner #(
  parameter int CHANNEL   = 1,
  parameter int AVG_SHIFT = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  adc_sample_conditioner_if.slave       bus
);

  localparam logic [4:0] CHANNEL_ID = CHANNEL[4:0];
  localparam logic [0:0] EMPTY      = 1'b0;
  localparam logic [0:0] FULL       = 1'b1;

  if (AVG_SHIFT < 1 || AVG_SHIFT > 12) begin : g_bad_shift
    $error("AVG_SHIFT out of range 1..12");
  end

  logic        accept_s;
  logic [11:0] x_s;
  logic        sample_valid_s;
  logic [15:0] sample_data_s;

  assign accept_s = bus.adc_response_valid && (bus.adc_response_channel == CHANNEL_ID);
  assign x_s      = {~bus.adc_response_data[11], bus.adc_response_data[10:0]};

`ifdef ADC_DC_REMOVE_EN
  localparam int ACC_W = 13 + AVG_SHIFT;

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] x_ext_s;
  logic signed [ACC_W-1:0] dc_s;
  logic signed [ACC_W-1:0] diff_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic        [ACC_W+3:0] scaled_s;
  logic        [ACC_W-12:0] scaled_top_s;
  logic        [15:0]      stage_data_s;
  logic                    stage_valid_r;
  logic        [15:0]      stage_data_r;

  // DC estimate is taken from the accumulator before this beat updates it.
  always_comb begin
    x_ext_s      = {{(ACC_W-12){x_s[11]}}, x_s};
    dc_s         = acc_r >>> AVG_SHIFT;
    diff_s       = x_ext_s - dc_s;
    acc_next_s   = acc_r + x_ext_s - dc_s;
    scaled_s     = {diff_s, 4'b0000};
    scaled_top_s = scaled_s[ACC_W+3:15];
    if ((&scaled_top_s) || !(|scaled_top_s)) begin
      stage_data_s = scaled_s[15:0];
    end else if (scaled_s[ACC_W+3]) begin
      stage_data_s = 16'h8000;
    end else begin
      stage_data_s = 16'h7FFF;
    end
  end

  // Accumulator and the extra pipeline stage introduced by DC removal.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      acc_r         <= '0;
      stage_valid_r <= 1'b0;
      stage_data_r  <= 16'h0000;
    end else begin
      stage_valid_r <= accept_s;
      if (accept_s) begin
        acc_r        <= acc_next_s;
        stage_data_r <= stage_data_s;
      end
    end
  end

  assign sample_valid_s = stage_valid_r;
  assign sample_data_s  = stage_data_r;
`else
  assign sample_valid_s = accept_s;
  assign sample_data_s  = {x_s, 4'b0000};
`endif

  logic [0:0]  state_r;
  logic [0:0]  state_next_s;
  logic [15:0] out_data_r;
  logic [15:0] out_data_next_s;
  logic [7:0]  overrun_r;
  logic [7:0]  overrun_next_s;

  // Output holder: a new sample always wins; it only counts as an overrun if the old one was not taken.
  always_comb begin
    state_next_s    = state_r;
    out_data_next_s = out_data_r;
    overrun_next_s  = overrun_r;
    case (state_r)
      EMPTY: begin
        if (sample_valid_s) begin
          state_next_s    = FULL;
          out_data_next_s = sample_data_s;
        end else begin
          state_next_s    = EMPTY;
        end
      end
      FULL: begin
        if (sample_valid_s) begin
          out_data_next_s = sample_data_s;
          if (!bus.out_ready && (overrun_r != 8'hFF)) begin
            overrun_next_s = overrun_r + 8'd1;
          end else begin
            overrun_next_s = overrun_r;
          end
        end else if (bus.out_ready) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // Output holder state, data and overrun counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r    <= EMPTY;
      out_data_r <= 16'h0000;
      overrun_r  <= 8'h00;
    end else begin
      state_r    <= state_next_s;
      out_data_r <= out_data_next_s;
      overrun_r  <= overrun_next_s;
    end
  end

  assign bus.out_valid     = (state_r == FULL);
  assign bus.out_data      = out_data_r;
  assign bus.overrun_count = overrun_r;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed self-checking bench for adc_sample_conditioner; the ADC_DC_REMOVE_EN build runs the DC-removal vectors.
module tb_adc_sample_conditioner;

  logic clk;
  logic rst_n;
  int   checks_total;
  int   checks_failed;

  adc_sample_conditioner_if bus ();

  adc_sample_conditioner #(
    .CHANNEL   (1),
    .AVG_SHIFT (2)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total = checks_total + 1;
    if (observed !== expected) begin
      checks_failed = checks_failed + 1;
      $display("FAIL %s got=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] ch, input logic [11:0] d);
    bus.adc_response_valid   = 1'b1;
    bus.adc_response_channel = ch;
    bus.adc_response_data    = d;
    tick();
    bus.adc_response_valid   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [15:0] prev;
    checks_total             = 0;
    checks_failed            = 0;
    rst_n                    = 1'b0;
    bus.adc_response_valid   = 1'b0;
    bus.adc_response_channel = 5'd0;
    bus.adc_response_data    = 12'h000;
    bus.out_ready            = 1'b0;
    #2;
    check("rst_valid",   {31'd0, bus.out_valid}, 32'd0);
    check("rst_data",    {16'd0, bus.out_data},  32'd0);
    check("rst_overrun", {24'd0, bus.overrun_count}, 32'd0);
    #21;
    rst_n = 1'b1;
    tick();

`ifdef ADC_DC_REMOVE_EN
    // Latency is two cycles with DC removal.
    bus.out_ready = 1'b1;
    beat(5'd1, 12'hA00);
    check("dc_lat_n1_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("dc_lat_n2_valid", {31'd0, bus.out_valid}, 32'd1);
    check("dc_lat_n2_data",  {16'd0, bus.out_data},  32'h2000);
    tick();
    check("dc_drain_valid",  {31'd0, bus.out_valid}, 32'd0);

    beat(5'd0, 12'hFFF);
    tick();
    check("dc_ch0_valid",    {31'd0, bus.out_valid}, 32'd0);

    do_reset();
    bus.adc_response_valid   = 1'b1;
    bus.adc_response_channel = 5'd1;
    bus.adc_response_data    = 12'hA00;
    tick();
    tick();
    check("dc_s0", {16'd0, bus.out_data}, 32'h2000);
    tick();
    check("dc_s1", {16'd0, bus.out_data}, 32'h1800);
    tick();
    check("dc_s2", {16'd0, bus.out_data}, 32'h1200);
    tick();
    check("dc_s3", {16'd0, bus.out_data}, 32'h0D80);
    check("dc_s3_valid", {31'd0, bus.out_valid}, 32'd1);
    prev = bus.out_data;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("dc_decay", {31'd0, (bus.out_data <= prev) && !bus.out_data[15]}, 32'd1);
      prev = bus.out_data;
    end
    check("dc_overrun", {24'd0, bus.overrun_count}, 32'd0);
    bus.adc_response_valid = 1'b0;
`else
    // Basic conversion with immediate consumption.
    bus.out_ready = 1'b1;
    beat(5'd1, 12'hC00);
    check("c00_valid", {31'd0, bus.out_valid}, 32'd1);
    check("c00_data",  {16'd0, bus.out_data},  32'h4000);
    tick();
    check("c00_drain", {31'd0, bus.out_valid}, 32'd0);

    beat(5'd1, 12'h000);
    check("neg_full_scale", {16'd0, bus.out_data}, 32'h8000);
    beat(5'd1, 12'h7FF);
    check("minus_one_lsb",  {16'd0, bus.out_data}, 32'hFFF0);
    tick();

    beat(5'd0, 12'hFFF);
    check("ch0_valid",   {31'd0, bus.out_valid}, 32'd0);
    check("ch0_overrun", {24'd0, bus.overrun_count}, 32'd0);
    beat(5'd2, 12'h123);
    check("ch2_valid",   {31'd0, bus.out_valid}, 32'd0);

    // Overwrite while the consumer stalls.
    bus.out_ready = 1'b0;
    beat(5'd1, 12'h800);
    beat(5'd1, 12'h900);
    beat(5'd1, 12'hA00);
    check("ovw_data",    {16'd0, bus.out_data}, 32'h2000);
    check("ovw_overrun", {24'd0, bus.overrun_count}, 32'd2);
    tick();
    check("stall_hold",  {16'd0, bus.out_data}, 32'h2000);
    check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("xfer_valid",  {31'd0, bus.out_valid}, 32'd0);

    // Transfer and new sample in the same cycle is not an overrun.
    beat(5'd1, 12'h800);
    bus.out_ready = 1'b1;
    beat(5'd1, 12'h400);
    bus.out_ready = 1'b0;
    check("swap_valid",   {31'd0, bus.out_valid}, 32'd1);
    check("swap_data",    {16'd0, bus.out_data},  32'hC000);
    check("swap_overrun", {24'd0, bus.overrun_count}, 32'd2);

    // Asynchronous reset between edges with a held sample.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      beat(5'd1, 12'hB00);
    end
    check("pre_rst_overrun", {24'd0, bus.overrun_count}, 32'd5);
    check("pre_rst_valid",   {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid",   {31'd0, bus.out_valid}, 32'd0);
    check("async_overrun", {24'd0, bus.overrun_count}, 32'd0);
    check("async_data",    {16'd0, bus.out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    beat(5'd1, 12'h900);
    check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_rst_data",  {16'd0, bus.out_data},  32'h1000);

    // Saturation of the overrun counter.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      beat(5'd1, 12'h800 + 12'(i));
    end
    check("sat_overrun", {24'd0, bus.overrun_count}, 32'd255);
    check("sat_data",    {16'd0, bus.out_data}, 32'h12B0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_total, checks_failed);
    $finish;
  end

endmodule
